// File: rtl/er_pkg.sv
// Shared types and constants for the sprite DMA: state encoding and sprite RAM geometry.
package er_pkg;
    localparam int SPR_BYTES = 512;
    localparam int SPR_AW    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } dma_state_t;
endpackage

// File: rtl/er_sprite_dma.sv
// Sprite DMA: copies 512-byte CPU sprite RAM into the back bank of a double buffer, then swaps banks.
// Build option ER_DMA_VBLANK_SYNC_EN holds a pending transfer until vblank.
module er_sprite_dma
    import er_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dma_swap,
    input  logic              cpu_wr,
    input  logic              vblank,
    output logic [SPR_AW-1:0] src_addr,
    input  logic [7:0]        src_data,
    output logic              dst_we,
    output logic [SPR_AW:0]   dst_addr,
    output logic [7:0]        dst_data,
    output logic              disp_bank,
    output logic              busy
);

    dma_state_t        state;
    logic [SPR_AW-1:0] cnt;
    logic              pending;
    logic              req;
    logic              start;

    assign req = dma_swap & cpu_wr;

`ifdef ER_DMA_VBLANK_SYNC_EN
    assign start = pending & vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign start = pending;
`endif

    // The counter is parked at 0 outside COPY, so it doubles as the read address.
    assign src_addr = cnt;

    // Sprite RAM data lands one cycle after its address, aligned with the registered write strobe.
    assign dst_data = dst_we ? src_data : 8'h00;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            cnt       <= '0;
            disp_bank <= 1'b0;
            busy      <= 1'b0;
            dst_we    <= 1'b0;
            dst_addr  <= '0;
        end else begin
            pending <= pending | req;
            dst_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Requests landing in this same cycle coalesce into the transfer now starting.
                        pending <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= COPY;
                    end
                end
                COPY: begin
                    dst_we   <= 1'b1;
                    dst_addr <= {~disp_bank, cnt};
                    if (cnt == SPR_AW'(SPR_BYTES - 1)) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= SWAP;
                end
                SWAP: begin
                    disp_bank <= ~disp_bank;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/er_sprite_dma.md
ER_SPRITE_DMA -- requirements
Module: er_sprite_dma

Interface
REQ-001 SHALL have port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port dma_swap  in  1  decoder strobe for the DMA/swap register.
REQ-004 SHALL have port cpu_wr  in  1  CPU write qualifier; a request is dma_swap & cpu_wr, sampled once per cycle.
REQ-005 SHALL have port vblank  in  1  video vertical blank, synchronous to clk_sys.
REQ-006 SHALL have port src_addr  out  9  sprite RAM read address (CPU sprite RAM, 512 bytes).
REQ-007 SHALL have port src_data  in  8  sprite RAM read data, valid one cycle after src_addr.
REQ-008 SHALL have port dst_we  out  1  sprite buffer write enable.
REQ-009 SHALL have port dst_addr  out  10  buffer write address; bit 9 is the bank, bits 8:0 are the byte index.
REQ-010 SHALL have port dst_data  out  8  buffer write data.
REQ-011 SHALL have port disp_bank  out  1  bank the sprite renderer reads.
REQ-012 SHALL have port busy  out  1  high while a transfer is in progress.

Function
REQ-013 SHALL implement states IDLE, COPY, DRAIN, SWAP.
REQ-014 SHALL set a one-deep pending flag on any request; extra requests while pending SHALL coalesce.
REQ-015 IDLE with pending (and start condition, REQ-027/028) SHALL clear pending, zero the counter, go to COPY.
REQ-016 With start seen in IDLE at cycle T, COPY SHALL occupy T+1..T+512 with src_addr = counter = 0..511.
REQ-017 Counter SHALL be 9 bits; at 511 COPY SHALL go to DRAIN (no wrap to 0 inside COPY).
REQ-018 dst_we SHALL assert in T+2..T+513 (exactly 512 cycles), dst_addr = {~disp_bank, previous src_addr}, dst_data = src_data.
REQ-019 DRAIN (T+513) SHALL write byte 511 and go to SWAP.
REQ-020 SWAP (T+514) SHALL toggle disp_bank (new value visible T+515) and go to IDLE.
REQ-021 busy SHALL be high T+1..T+514 inclusive, low otherwise.
REQ-022 A request arriving in any non-IDLE state, including SWAP, SHALL set pending; the next transfer SHALL start from IDLE after SWAP and target the new back bank.
REQ-023 dst_we SHALL never assert in IDLE or SWAP; writes SHALL never target disp_bank.
REQ-024 src_addr SHALL hold 0 outside COPY.

Reset
REQ-025 On reset: state IDLE, pending 0, counter 0, disp_bank 0, busy 0, dst_we 0, src_addr 0, dst_addr 0, dst_data 0.
REQ-026 Reset mid-transfer SHALL abandon it with no swap; a request in the reset cycle SHALL be ignored.

Configuration
REQ-027 With ER_DMA_VBLANK_SYNC_EN defined, IDLE SHALL leave only when pending & vblank; pending SHALL wait across active video.
REQ-028 Without ER_DMA_VBLANK_SYNC_EN, IDLE SHALL leave when pending, regardless of vblank; vblank SHALL be unused.

Structure
REQ-029 Shared package er_pkg SHALL hold the state enum typedef and constants SPR_BYTES=512 and SPR_AW=9.
REQ-030 No sub-module SHALL be used; counter, pipeline register and FSM SHALL be inline.

Verification
REQ-031 Single request, macro off, src_data = src_addr[7:0] -> 512 writes to bank 1 with dst_data = index[7:0]; disp_bank 0->1 at T+515; busy for 514 cycles.
REQ-032 Second request at T+100 -> second transfer starts from IDLE after SWAP at T+514, writes bank 0, disp_bank returns to 0 at T+1030.
REQ-033 Three requests during one transfer -> exactly one follow-up transfer (coalesced).
REQ-034 Reset asserted at T+200 -> disp_bank stays 0, busy drops the next cycle, no further dst_we.
REQ-035 Macro on, request with vblank=0 for 1000 cycles -> busy stays low; vblank rises at cycle C -> COPY begins C+1.
REQ-036 Request with dma_swap=1, cpu_wr=0 -> no transfer, pending stays 0.
